// File: rtl/uart_rs232_tx.sv
// 8-N-1 UART transmitter with a small input FIFO, paced by a 16x-baud Tick enable.
// Define UART_TX_PARITY_EN to add a parity bit (ParOdd input, PARITY state).
module uart_rs232_tx #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Tick,
    input  logic       TxEn,
    input  logic [3:0] NBits,
`ifdef UART_TX_PARITY_EN
    input  logic       ParOdd,
`endif
    input  logic       WrEn,
    input  logic [7:0] TxData,
    output logic       TxReady,
    output logic       Tx,
    output logic       TxBusy,
    output logic       TxDone,
    output logic [7:0] count_Tx
);
    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam int unsigned TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
    logic [3:0]      bit_cnt_q, bit_cnt_d;
    logic [3:0]      nbits_q, nbits_d;
    logic [7:0]      shift_q, shift_d;
    logic            tx_q, tx_d;
    logic            done_q, done_d;
    logic [7:0]      count_q, count_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   fill_q, fill_d;
    logic [7:0]      fifo_mem_q [FIFO_DEPTH];
`ifdef UART_TX_PARITY_EN
    logic            par_q, par_d;
`endif

    logic            fifo_full, fifo_empty, push, pop, tick_last, can_start;
    logic [3:0]      nbits_clamped;
    logic [7:0]      head;

    always_comb begin
        fifo_full     = (fill_q == CW'(FIFO_DEPTH));
        fifo_empty    = (fill_q == '0);
        push          = WrEn && !fifo_full;
        head          = fifo_mem_q[rd_ptr_q];
        nbits_clamped = (NBits >= 4'd5 && NBits <= 4'd8) ? NBits : 4'd8;
        tick_last     = Tick && (tick_cnt_q == TICK_LAST);
        can_start     = TxEn && !fifo_empty;

        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        nbits_d    = nbits_q;
        shift_d    = shift_q;
        done_d     = 1'b0;
        count_d    = count_q;
        pop        = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d      = par_q;
`endif

        if (state_q != S_IDLE && Tick) begin
            tick_cnt_d = tick_last ? '0 : tick_cnt_q + TW'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (can_start) begin
                    pop     = 1'b1;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (tick_last) begin
                    bit_cnt_d = '0;
                    state_d   = S_DATA;
                end
            end
            S_DATA: begin
                if (tick_last) begin
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q + 4'd1 == nbits_q) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (tick_last) state_d = S_STOP;
            end
`endif
            S_STOP: begin
                if (tick_last) begin
                    done_d  = 1'b1;
                    count_d = count_q + 8'd1;
                    // Popping here chains the next start bit with no idle gap.
                    if (can_start) begin
                        pop     = 1'b1;
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (pop) begin
            shift_d    = head;
            nbits_d    = nbits_clamped;
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
`ifdef UART_TX_PARITY_EN
            par_d      = ^(head & (8'hFF >> (4'd8 - nbits_clamped))) ^ ParOdd;
`endif
        end

        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        fill_d   = fill_q + CW'(push) - CW'(pop);

        // Tx follows the next state so the line is a clean flop output.
        tx_d = 1'b1;
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: tx_d = par_d;
`endif
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q    <= S_IDLE;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            nbits_q    <= 4'd8;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            done_q     <= 1'b0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fill_q     <= '0;
`ifdef UART_TX_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            nbits_q    <= nbits_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            done_q     <= done_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fill_q     <= fill_d;
`ifdef UART_TX_PARITY_EN
            par_q      <= par_d;
`endif
        end
    end

    always_ff @(posedge Clk) begin
        if (push) fifo_mem_q[wr_ptr_q] <= TxData;
    end

    assign TxReady  = !fifo_full;
    assign Tx       = tx_q;
    assign TxBusy   = (state_q != S_IDLE);
    assign TxDone   = done_q;
    assign count_Tx = count_q;

endmodule

// File: tb/tb_uart_rs232_tx.sv
// Directed bench for uart_rs232_tx: a line monitor decodes frames against a queue of expected frames.
module tb_uart_rs232_tx;
    logic       Clk = 1'b0;
    logic       Rst, Tick, TxEn, WrEn;
    logic [3:0] NBits;
    logic [7:0] TxData;
`ifdef UART_TX_PARITY_EN
    logic       ParOdd;
`endif
    logic       TxReady, Tx, TxBusy, TxDone;
    logic [7:0] count_Tx;

    int checks = 0;
    int errors = 0;
    int exp_frames = 0;
    int done_cnt = 0;
    bit mon_busy = 1'b0;

    typedef struct {
        logic [7:0] data;
        int         nb;
        bit         par_en;
        bit         par;
        bit         b2b;
    } frame_t;
    frame_t exp_q[$];

    uart_rs232_tx #(.FIFO_DEPTH(4), .OVERSAMPLE(16)) dut (
        .Clk(Clk), .Rst(Rst), .Tick(Tick), .TxEn(TxEn), .NBits(NBits),
`ifdef UART_TX_PARITY_EN
        .ParOdd(ParOdd),
`endif
        .WrEn(WrEn), .TxData(TxData), .TxReady(TxReady), .Tx(Tx),
        .TxBusy(TxBusy), .TxDone(TxDone), .count_Tx(count_Tx)
    );

    always #5 Clk = ~Clk;

    // One Tick every 4 Clk, changed just after the rising edge.
    initial begin : tick_gen
        int div;
        div = 0;
        Tick = 1'b0;
        forever begin
            @(posedge Clk);
            #1;
            div = (div == 3) ? 0 : div + 1;
            Tick = (div == 3);
        end
    end

    initial begin : done_counter
        forever begin
            @(negedge Clk);
            if (TxDone === 1'b1) done_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int clamp_nb(input logic [3:0] n);
        return (n >= 4'd5 && n <= 4'd8) ? int'(n) : 8;
    endfunction

    task automatic expect_frame(input logic [7:0] d, input bit b2b);
        frame_t e;
        e.data = d;
        e.nb   = clamp_nb(NBits);
        e.b2b  = b2b;
        e.par  = 1'b0;
        for (int i = 0; i < e.nb; i++) e.par ^= d[i];
`ifdef UART_TX_PARITY_EN
        e.par_en = 1'b1;
        e.par ^= ParOdd;
`else
        e.par_en = 1'b0;
`endif
        exp_q.push_back(e);
        exp_frames++;
    endtask

    task automatic push(input logic [7:0] d);
        @(negedge Clk);
        WrEn = 1'b1;
        TxData = d;
        @(negedge Clk);
        WrEn = 1'b0;
    endtask

    task automatic push_exp(input logic [7:0] d, input bit b2b);
        push(d);
        expect_frame(d, b2b);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge Clk);
            #2;
            if (exp_q.size() == 0 && !mon_busy && TxBusy === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        chk("idle_reached", {31'd0, ok}, 32'd1);
    endtask

    task automatic wait_tx_low();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (Tx === 1'b0) begin
                ok = 1'b1;
                break;
            end
            @(negedge Clk);
        end
        chk("tx_start_seen", {31'd0, ok}, 32'd1);
    endtask

    // Decodes each frame on the line by counting Ticks; samples every bit at its 8th Tick.
    initial begin : monitor
        frame_t e;
        bit     have_edge;
        bit     abort;
        int     gap_ticks, t, b, total, guard;
        logic   ev;
        have_edge = 1'b0;
        gap_ticks = 0;
        forever begin
            if (!have_edge) begin
                @(negedge Clk);
                #1;
            end
            have_edge = 1'b0;
            if (Rst === 1'b1) begin
                gap_ticks = 0;
            end else if (Tx === 1'b0) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_frame", {31'd0, Tx}, 32'd1);
                    guard = 0;
                    while (Tx === 1'b0 && guard < 2000) begin
                        @(negedge Clk);
                        #1;
                        guard++;
                    end
                end else begin
                    e = exp_q.pop_front();
                    mon_busy = 1'b1;
                    if (e.b2b) chk($sformatf("b2b_gap_%02h", e.data), gap_ticks, 0);
                    total = e.nb + 2 + (e.par_en ? 1 : 0);
                    abort = 1'b0;
                    t = 0;
                    b = 0;
                    while (b < total && !abort) begin
                        if (Rst === 1'b1) begin
                            abort = 1'b1;
                        end else begin
                            if (Tick === 1'b1) begin
                                t++;
                                if (t == 8) begin
                                    if (b == 0) ev = 1'b0;
                                    else if (b <= e.nb) ev = e.data[b-1];
                                    else if (e.par_en && b == e.nb + 1) ev = e.par;
                                    else ev = 1'b1;
                                    chk($sformatf("bit%0d_of_%02h", b, e.data), {31'd0, Tx}, {31'd0, ev});
                                end
                                if (t == 16) begin
                                    t = 0;
                                    b++;
                                end
                            end
                            if (b < total) begin
                                @(negedge Clk);
                                #1;
                            end
                        end
                    end
                    if (!abort) begin
                        @(negedge Clk);
                        #1;
                        chk($sformatf("txdone_%02h", e.data), {31'd0, TxDone}, 32'd1);
                        have_edge = 1'b1;
                    end
                    gap_ticks = 0;
                    mon_busy = 1'b0;
                end
            end else if (Tick === 1'b1) begin
                gap_ticks++;
            end
        end
    end

    initial begin : stimulus
        int n;
        Rst = 1'b1;
        TxEn = 1'b0;
        WrEn = 1'b0;
        NBits = 4'd8;
        TxData = 8'h00;
`ifdef UART_TX_PARITY_EN
        ParOdd = 1'b0;
`endif
        repeat (3) @(negedge Clk);
        chk("rst_Tx", {31'd0, Tx}, 32'd1);
        chk("rst_TxBusy", {31'd0, TxBusy}, 32'd0);
        chk("rst_TxDone", {31'd0, TxDone}, 32'd0);
        chk("rst_count", {24'd0, count_Tx}, 32'd0);
        chk("rst_TxReady", {31'd0, TxReady}, 32'd1);
        Rst = 1'b0;

        // Single 0x55 frame; a data bit level lasts exactly 64 Clk.
        TxEn = 1'b1;
        push_exp(8'h55, 1'b0);
        wait_tx_low();
        n = 0;
        while (Tx !== 1'b1 && n < 200) begin
            @(negedge Clk);
            n++;
        end
        n = 0;
        while (Tx === 1'b1 && n < 200) begin
            @(negedge Clk);
            n++;
        end
        chk("bit0_len_clk", n, 64);
        wait_idle();
        chk("count_after_55", {24'd0, count_Tx}, exp_frames & 255);
        chk("txdone_pulses_55", done_cnt, 1);

        // Fill the FIFO while held, drop a push when full, then release back-to-back.
        TxEn = 1'b0;
        push_exp(8'hA3, 1'b0);
        push_exp(8'h0F, 1'b1);
        push_exp(8'hFF, 1'b1);
        chk("ready_after_3", {31'd0, TxReady}, 32'd1);
        push_exp(8'h00, 1'b1);
        chk("ready_after_4", {31'd0, TxReady}, 32'd0);
        push(8'h11);
        chk("ready_after_drop", {31'd0, TxReady}, 32'd0);
        repeat (100) @(negedge Clk);
        chk("held_Tx", {31'd0, Tx}, 32'd1);
        chk("held_TxBusy", {31'd0, TxBusy}, 32'd0);
        TxEn = 1'b1;
        @(negedge Clk);
        chk("start_TxBusy", {31'd0, TxBusy}, 32'd1);
        chk("start_Tx", {31'd0, Tx}, 32'd0);
        wait_idle();
        chk("count_after_burst", {24'd0, count_Tx}, exp_frames & 255);
        chk("txdone_pulses_burst", done_cnt, 5);

        // 5-bit frame; changing NBits mid-frame must not alter it. NBits=2 means 8.
        NBits = 4'd5;
        push_exp(8'h3F, 1'b0);
        wait_tx_low();
        NBits = 4'd8;
        wait_idle();
        NBits = 4'd2;
        push_exp(8'hC5, 1'b0);
        wait_idle();
        NBits = 4'd8;
        chk("count_after_nbits", {24'd0, count_Tx}, exp_frames & 255);

        // Dropping TxEn mid-frame finishes that frame and holds the next byte.
        push_exp(8'h5A, 1'b0);
        push(8'h96);
        wait_tx_low();
        TxEn = 1'b0;
        wait_idle();
        repeat (200) @(negedge Clk);
        chk("hold_Tx", {31'd0, Tx}, 32'd1);
        chk("hold_TxBusy", {31'd0, TxBusy}, 32'd0);
        chk("count_after_hold", {24'd0, count_Tx}, exp_frames & 255);
        expect_frame(8'h96, 1'b0);
        TxEn = 1'b1;
        wait_idle();
        chk("count_after_release", {24'd0, count_Tx}, exp_frames & 255);

`ifdef UART_TX_PARITY_EN
        ParOdd = 1'b0;
        push_exp(8'h07, 1'b0);
        wait_idle();
        ParOdd = 1'b1;
        push_exp(8'h07, 1'b0);
        wait_idle();
        ParOdd = 1'b0;
        chk("count_after_parity", {24'd0, count_Tx}, exp_frames & 255);
`endif

        // Reset during a data bit of 0x81 with another byte queued.
        push_exp(8'h81, 1'b0);
        push(8'h42);
        wait_tx_low();
        repeat (160) @(negedge Clk);
        chk("tx_before_rst", {31'd0, Tx}, 32'd0);
        Rst = 1'b1;
        @(negedge Clk);
        chk("midrst_Tx", {31'd0, Tx}, 32'd1);
        chk("midrst_TxReady", {31'd0, TxReady}, 32'd1);
        chk("midrst_count", {24'd0, count_Tx}, 32'd0);
        chk("midrst_TxBusy", {31'd0, TxBusy}, 32'd0);
        Rst = 1'b0;
        exp_frames = 0;
        repeat (300) @(negedge Clk);
        chk("fifo_empty_after_rst", {31'd0, TxBusy}, 32'd0);
        push_exp(8'h33, 1'b0);
        wait_idle();
        chk("count_after_rst_frame", {24'd0, count_Tx}, exp_frames & 255);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
